// File: rtl/gth_qpll_reset_ctrl_if.sv
// gth_qpll_reset_ctrl_if
//   Control/status bundle between the QPLL reset sequencer and its users.
//   master : system side (drives enables, soft resets and the raw lock pins)
//   slave  : the sequencer itself
//   quad_en, soft_reset, qpll_lock        : per-quad inputs to the sequencer
//   qpll_reset, quad_locked, lock_lost,
//   quad_fail, all_locked, retry_cnt      : registered sequencer outputs
`timescale 1ns/1ps
interface gth_qpll_reset_ctrl_if #(
    parameter int NUM_QUADS = 1
);
    logic [NUM_QUADS-1:0]   quad_en;
    logic [NUM_QUADS-1:0]   soft_reset;
    logic [NUM_QUADS-1:0]   qpll_lock;
    logic [NUM_QUADS-1:0]   qpll_reset;
    logic [NUM_QUADS-1:0]   quad_locked;
    logic [NUM_QUADS-1:0]   lock_lost;
    logic [NUM_QUADS-1:0]   quad_fail;
    logic                   all_locked;
    logic [4*NUM_QUADS-1:0] retry_cnt;

    modport master (
        output quad_en, soft_reset, qpll_lock,
        input  qpll_reset, quad_locked, lock_lost, quad_fail, all_locked, retry_cnt
    );

    modport slave (
        input  quad_en, soft_reset, qpll_lock,
        output qpll_reset, quad_locked, lock_lost, quad_fail, all_locked, retry_cnt
    );
endinterface

// File: rtl/gth_qpll_reset_ctrl.sv
// gth_qpll_reset_ctrl
//   Per-quad QPLL reset sequencer and lock supervisor for GTHE4 COMMON blocks.
//   Each quad: hold QPLL reset for RESET_CYCLES, wait for LOCK_FILTER
//   consecutive synchronised lock-high cycles, retry on LOCK_TIMEOUT up to
//   MAX_RETRIES times, re-reset on lock loss, park in FAIL when exhausted.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of gth_qpll_reset_ctrl_if (all outputs registered)
`timescale 1ns/1ps
module gth_qpll_reset_ctrl #(
    parameter int NUM_QUADS    = 1,
    parameter int RESET_CYCLES = 64,
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gth_qpll_reset_ctrl_if.slave   bus
);

    localparam int RST_W = $clog2(RESET_CYCLES) + 1;
    localparam int FLT_W = $clog2(LOCK_FILTER) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t               r_state   [NUM_QUADS];
    logic [RST_W-1:0]     r_rst_cnt [NUM_QUADS];
    logic [FLT_W-1:0]     r_flt_cnt [NUM_QUADS];
    logic [TO_W-1:0]      r_to_cnt  [NUM_QUADS];
    logic [3:0]           r_retry   [NUM_QUADS];

    logic [NUM_QUADS-1:0] r_sync1;
    logic [NUM_QUADS-1:0] r_sync2;
    logic [NUM_QUADS-1:0] r_qpll_reset;
    logic [NUM_QUADS-1:0] r_locked;
    logic [NUM_QUADS-1:0] r_lost;
    logic [NUM_QUADS-1:0] r_fail;
    logic                 r_all_locked;

    logic [NUM_QUADS-1:0] w_lk;
    logic [NUM_QUADS-1:0] w_filter_done;
    logic [NUM_QUADS-1:0] w_timeout;
    logic [NUM_QUADS-1:0] w_locked_nxt;

    assign w_lk = r_sync2;

    // Next-cycle lock status is needed both for quad_locked and for the
    // all_locked AND, so that both registers move on the same edge.
    always_comb begin
        w_filter_done = '0;
        w_timeout     = '0;
        w_locked_nxt  = '0;
        for (int unsigned q = 0; q < NUM_QUADS; q++) begin
            w_filter_done[q] = (r_state[q] == ST_WAIT_LOCK) && w_lk[q] &&
                               (r_flt_cnt[q] == FLT_LAST);
            w_timeout[q]     = (r_state[q] == ST_WAIT_LOCK) &&
                               (r_to_cnt[q] == TO_LAST);
            w_locked_nxt[q]  = bus.quad_en[q] && !bus.soft_reset[q] &&
                               (w_filter_done[q] ||
                                ((r_state[q] == ST_LOCKED) && w_lk[q]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_qpll_reset <= '1;
            r_locked     <= '0;
            r_lost       <= '0;
            r_fail       <= '0;
            r_all_locked <= 1'b0;
            for (int unsigned q = 0; q < NUM_QUADS; q++) begin
                r_state[q]   <= ST_IDLE;
                r_rst_cnt[q] <= '0;
                r_flt_cnt[q] <= '0;
                r_to_cnt[q]  <= '0;
                r_retry[q]   <= '0;
            end
        end else begin
            r_sync1      <= bus.qpll_lock;
            r_sync2      <= r_sync1;
            r_locked     <= w_locked_nxt;
            r_all_locked <= (&(w_locked_nxt | ~bus.quad_en)) & (|bus.quad_en);

            for (int unsigned q = 0; q < NUM_QUADS; q++) begin
                // Only WAIT_LOCK and LOCKED release the QPLL reset.
                r_qpll_reset[q] <= 1'b1;
                r_lost[q]       <= 1'b0;
                r_fail[q]       <= 1'b0;

                if (!bus.quad_en[q]) begin
                    r_state[q]   <= ST_IDLE;
                    r_rst_cnt[q] <= '0;
                    r_flt_cnt[q] <= '0;
                    r_to_cnt[q]  <= '0;
                    r_retry[q]   <= '0;
                end else if (bus.soft_reset[q]) begin
                    r_state[q]   <= ST_RESET;
                    r_rst_cnt[q] <= '0;
                    r_flt_cnt[q] <= '0;
                    r_to_cnt[q]  <= '0;
                    r_retry[q]   <= '0;
                end else begin
                    case (r_state[q])
                        ST_IDLE: begin
                            r_state[q]   <= ST_RESET;
                            r_rst_cnt[q] <= '0;
                        end
                        ST_RESET: begin
                            if (r_rst_cnt[q] == RST_LAST) begin
                                r_state[q]      <= ST_WAIT_LOCK;
                                r_to_cnt[q]     <= '0;
                                r_flt_cnt[q]    <= '0;
                                r_qpll_reset[q] <= 1'b0;
                            end else begin
                                r_rst_cnt[q] <= r_rst_cnt[q] + 1'b1;
                            end
                        end
                        ST_WAIT_LOCK: begin
                            // Filter completion is tested first: lock beats a
                            // coincident timeout.
                            if (w_filter_done[q]) begin
                                r_state[q]      <= ST_LOCKED;
                                r_retry[q]      <= '0;
                                r_qpll_reset[q] <= 1'b0;
                            end else if (w_timeout[q]) begin
                                if (r_retry[q] < RETRY_MAX) begin
                                    r_state[q]   <= ST_RESET;
                                    r_rst_cnt[q] <= '0;
                                    if (r_retry[q] != 4'hF) begin
                                        r_retry[q] <= r_retry[q] + 4'd1;
                                    end
                                end else begin
                                    r_state[q] <= ST_FAIL;
                                    r_fail[q]  <= 1'b1;
                                end
                            end else begin
                                r_qpll_reset[q] <= 1'b0;
                                r_to_cnt[q]     <= r_to_cnt[q] + 1'b1;
                                r_flt_cnt[q]    <= w_lk[q] ? r_flt_cnt[q] + 1'b1 : '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (!w_lk[q]) begin
                                r_state[q]   <= ST_RESET;
                                r_rst_cnt[q] <= '0;
                                r_lost[q]    <= 1'b1;
                            end else begin
                                r_qpll_reset[q] <= 1'b0;
                            end
                        end
                        ST_FAIL: begin
                            r_fail[q] <= 1'b1;
                        end
                        default: begin
                            r_state[q] <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.qpll_reset  = r_qpll_reset;
    assign bus.quad_locked = r_locked;
    assign bus.lock_lost   = r_lost;
    assign bus.quad_fail   = r_fail;
    assign bus.all_locked  = r_all_locked;

    for (genvar g = 0; g < NUM_QUADS; g++) begin : g_retry
        assign bus.retry_cnt[4*g +: 4] = r_retry[g];
    end

endmodule

// File: tb/tb_gth_qpll_reset_ctrl.sv
// tb_gth_qpll_reset_ctrl
//   Directed scenarios followed by a randomised soak for gth_qpll_reset_ctrl.
//   Expected outputs come from a timestamp-based reference model: each quad
//   records the edge at which its current phase began and the raw lock
//   history, and transitions are derived from elapsed edges and run lengths.
`timescale 1ns/1ps
module tb_gth_qpll_reset_ctrl;

    localparam int NQ = 2;
    localparam int RC = 8;
    localparam int LF = 4;
    localparam int LT = 100;
    localparam int MR = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RESET  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_LOCKED = 3;
    localparam int M_FAIL   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gth_qpll_reset_ctrl_if #(.NUM_QUADS(NQ)) bus ();

    gth_qpll_reset_ctrl #(
        .NUM_QUADS   (NQ),
        .RESET_CYCLES(RC),
        .LOCK_FILTER (LF),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_mode  [NQ];
    int              m_t     [NQ];
    int              m_retry [NQ];
    logic [NQ-1:0]   m_lost;
    int              m_edge;
    logic [NQ-1:0]   m_raw [$];

    function automatic bit m_lk(input int q, input int k);
        logic [NQ-1:0] v;
        if (k < 2) return 1'b0;
        v = m_raw[k-2];
        return v[q];
    endfunction

    function automatic void model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_mode[q]  = M_IDLE;
            m_t[q]     = 0;
            m_retry[q] = 0;
        end
        m_lost = '0;
        m_raw.delete();
        m_edge = 0;
    endfunction

    function automatic void model_step(input logic [NQ-1:0] en, input logic [NQ-1:0] sr,
                                       input logic [NQ-1:0] raw);
        int n;
        int run;
        n = m_edge;
        m_raw.push_back(raw);
        m_lost = '0;
        for (int q = 0; q < NQ; q++) begin
            if (!en[q]) begin
                m_mode[q]  = M_IDLE;
                m_retry[q] = 0;
            end else if (sr[q]) begin
                m_mode[q]  = M_RESET;
                m_t[q]     = n;
                m_retry[q] = 0;
            end else begin
                case (m_mode[q])
                    M_IDLE: begin
                        m_mode[q] = M_RESET;
                        m_t[q]    = n;
                    end
                    M_RESET: begin
                        if (n - m_t[q] == RC) begin
                            m_mode[q] = M_WAIT;
                            m_t[q]    = n;
                        end
                    end
                    M_WAIT: begin
                        run = 0;
                        for (int k = n; k > m_t[q] && run < LF && m_lk(q, k); k--) run++;
                        if (run >= LF) begin
                            m_mode[q]  = M_LOCKED;
                            m_retry[q] = 0;
                        end else if (n - m_t[q] == LT) begin
                            if (m_retry[q] < MR) begin
                                m_retry[q]++;
                                m_mode[q] = M_RESET;
                                m_t[q]    = n;
                            end else begin
                                m_mode[q] = M_FAIL;
                            end
                        end
                    end
                    M_LOCKED: begin
                        if (!m_lk(q, n)) begin
                            m_lost[q] = 1'b1;
                            m_mode[q] = M_RESET;
                            m_t[q]    = n;
                        end
                    end
                    default: ;
                endcase
            end
        end
        m_edge++;
    endfunction

    // ---------------- stimulus state ----------------
    logic [NQ-1:0] en_v, sr_v, force_low, drv_lock, prev_qr;
    int  delay [NQ];
    int  block [NQ];
    int  since_fall [NQ];
    bit  blocked [NQ];
    bit  pat_mode [NQ];
    int  hi_run [NQ];
    int  last_width [NQ];
    int  fall_cnt [NQ];
    int  lost_cnt [NQ];
    bit  rand_mode = 1'b0;
    int  cyc = 0;
    int  pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

    task automatic bookkeeping_reset();
        prev_qr = '1;
        for (int q = 0; q < NQ; q++) begin
            since_fall[q] = -1;
            blocked[q]    = 1'b0;
            hi_run[q]     = 0;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_qpll_reset"}, 32'(bus.qpll_reset), 32'(2'b11));
        check({pfx, "_quad_locked"}, 32'(bus.quad_locked), 0);
        check({pfx, "_lock_lost"}, 32'(bus.lock_lost), 0);
        check({pfx, "_quad_fail"}, 32'(bus.quad_fail), 0);
        check({pfx, "_all_locked"}, 32'(bus.all_locked), 0);
        check({pfx, "_retry_cnt"}, 32'(bus.retry_cnt), 0);
    endtask

    task automatic run_cycle();
        logic [NQ-1:0]   e_qr, e_lk, e_fail;
        logic [4*NQ-1:0] e_retry;
        logic            e_all;
        if (rand_mode) begin
            sr_v      = '0;
            force_low = '0;
            for (int q = 0; q < NQ; q++) begin
                if ($urandom_range(0, 299) == 0) sr_v[q] = 1'b1;
                if ($urandom_range(0, 99) == 0) force_low[q] = 1'b1;
                if ($urandom_range(0, 249) == 0) en_v[q] = ~en_v[q];
            end
        end
        for (int q = 0; q < NQ; q++) begin
            bit p;
            if (pat_mode[q]) p = (since_fall[q] >= 0 && since_fall[q] < 8) ? (pat[since_fall[q]] != 0) : 1'b1;
            else             p = (since_fall[q] >= delay[q]);
            drv_lock[q] = !bus.qpll_reset[q] && !blocked[q] && !force_low[q] &&
                          (since_fall[q] >= 0) && p;
        end
        bus.quad_en    = en_v;
        bus.soft_reset = sr_v;
        bus.qpll_lock  = drv_lock;
        @(posedge clk);
        #1;
        cyc++;
        model_step(en_v, sr_v, drv_lock);

        for (int q = 0; q < NQ; q++) begin
            e_qr[q]          = (m_mode[q] == M_IDLE) || (m_mode[q] == M_RESET) || (m_mode[q] == M_FAIL);
            e_lk[q]          = (m_mode[q] == M_LOCKED);
            e_fail[q]        = (m_mode[q] == M_FAIL);
            e_retry[4*q +: 4] = 4'(m_retry[q]);
        end
        e_all = (&(e_lk | ~en_v)) & (|en_v);
        check("qpll_reset", 32'(bus.qpll_reset), 32'(e_qr));
        check("quad_locked", 32'(bus.quad_locked), 32'(e_lk));
        check("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
        check("quad_fail", 32'(bus.quad_fail), 32'(e_fail));
        check("all_locked", 32'(bus.all_locked), 32'(e_all));
        check("retry_cnt", 32'(bus.retry_cnt), 32'(e_retry));

        for (int q = 0; q < NQ; q++) begin
            if (bus.qpll_reset[q]) begin
                hi_run[q]++;
                since_fall[q] = -1;
            end else begin
                if (prev_qr[q]) begin
                    last_width[q] = hi_run[q];
                    fall_cnt[q]++;
                    since_fall[q] = 0;
                    if (rand_mode) begin
                        delay[q]   = $urandom_range(0, 12);
                        blocked[q] = ($urandom_range(0, 3) == 0);
                    end else begin
                        blocked[q] = (block[q] > 0);
                        if (block[q] > 0) block[q]--;
                    end
                end else begin
                    since_fall[q]++;
                end
                hi_run[q] = 0;
            end
            if (bus.lock_lost[q]) lost_cnt[q]++;
        end
        prev_qr = bus.qpll_reset;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t_drive, t_rise, t_fall, s, f, falls0, lost1, saw_r1, saw_drop;
        for (int q = 0; q < NQ; q++) begin
            delay[q] = 5; block[q] = 0; pat_mode[q] = 1'b0;
            last_width[q] = 0; fall_cnt[q] = 0; lost_cnt[q] = 0;
        end
        rst_n = 1'b0;
        en_v = '1; sr_v = '0; force_low = '0; drv_lock = '0;
        bus.quad_en = en_v; bus.soft_reset = sr_v; bus.qpll_lock = '0;
        bookkeeping_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk) rst_n = 1'b1;

        // 1: nominal bring-up
        t_drive = -1; t_rise = -1;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            if (t_drive < 0 && drv_lock[0]) t_drive = cyc;
            if (t_rise < 0 && bus.quad_locked[0]) t_rise = cyc;
        end
        check("nom_rst_width0", 32'(last_width[0]), RC);
        check("nom_rst_width1", 32'(last_width[1]), RC);
        // raw lock is driven one clock before the edge that samples it
        check("nom_lock_latency", 32'(t_rise - t_drive + 1), 2 + LF);
        check("nom_all_locked", 32'(bus.all_locked), 1);
        check("nom_retry", 32'(bus.retry_cnt), 0);

        // 2: first attempt times out, second locks
        block[0] = 1; lost1 = lost_cnt[1]; saw_r1 = 0;
        sr_v[0] = 1'b1; run_cycle(); sr_v[0] = 1'b0;
        for (int i = 0; i < 140; i++) begin
            run_cycle();
            if (bus.qpll_reset[0] && bus.retry_cnt[3:0] == 4'd1) saw_r1 = 1;
        end
        check("retry_seen1", 32'(saw_r1), 1);
        check("retry_width", 32'(last_width[0]), RC);
        check("retry_cleared", 32'(bus.retry_cnt[3:0]), 0);
        check("retry_q0_locked", 32'(bus.quad_locked[0]), 1);
        check("retry_q1_locked", 32'(bus.quad_locked[1]), 1);
        check("retry_q1_lost", 32'(lost_cnt[1] - lost1), 0);

        // 3: retries exhausted on quad 1, then soft reset recovery
        block[1] = 1000; falls0 = fall_cnt[1];
        sr_v[1] = 1'b1; run_cycle(); sr_v[1] = 1'b0;
        run_n(340);
        check("fail_pulses", 32'(fall_cnt[1] - falls0), MR + 1);
        check("fail_flag", 32'(bus.quad_fail[1]), 1);
        check("fail_qpll_reset", 32'(bus.qpll_reset[1]), 1);
        check("fail_retry", 32'(bus.retry_cnt[7:4]), MR);
        check("fail_all_locked", 32'(bus.all_locked), 0);
        block[1] = 0;
        sr_v[1] = 1'b1; run_cycle(); sr_v[1] = 1'b0;
        s = cyc; f = -1;
        check("sr_fail_clr", 32'(bus.quad_fail[1]), 0);
        check("sr_retry_clr", 32'(bus.retry_cnt[7:4]), 0);
        check("sr_qpll_reset", 32'(bus.qpll_reset[1]), 1);
        for (int i = 0; i < 20 && f < 0; i++) begin
            run_cycle();
            if (!bus.qpll_reset[1]) f = cyc;
        end
        check("sr_rst_width", 32'(f - s), RC);
        run_n(20);

        // 4: one-cycle lock loss on quad 0
        lost_cnt[0] = 0; saw_drop = 0;
        force_low[0] = 1'b1; run_cycle(); force_low[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            run_cycle();
            if (bus.lock_lost[0] && !bus.all_locked && !bus.quad_locked[0]) saw_drop = 1;
        end
        check("loss_pulses", 32'(lost_cnt[0]), 1);
        check("loss_drop", 32'(saw_drop), 1);
        check("loss_rst_width", 32'(last_width[0]), RC);
        check("loss_retry", 32'(bus.retry_cnt[3:0]), 0);
        check("loss_relocked", 32'(bus.quad_locked[0]), 1);

        // 5: glitchy lock 1,1,1,0,1,1,1,1 after reset release
        pat_mode[0] = 1'b1; t_fall = -1; t_rise = -1;
        sr_v[0] = 1'b1; run_cycle(); sr_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            run_cycle();
            if (t_fall < 0 && !bus.qpll_reset[0]) t_fall = cyc;
            if (t_fall >= 0 && t_rise < 0 && bus.quad_locked[0]) t_rise = cyc;
        end
        // last pattern sample hits the edge 8 cycles after the fall, plus sync lag
        check("glitch_lock_time", 32'(t_rise - t_fall), 8 + 2);
        pat_mode[0] = 1'b0;

        // 6a: disable quad 1 while locked
        en_v[1] = 1'b0; lost_cnt[1] = 0;
        run_n(10);
        check("dis_qpll_reset", 32'(bus.qpll_reset[1]), 1);
        check("dis_locked", 32'(bus.quad_locked[1]), 0);
        check("dis_no_lost", 32'(lost_cnt[1]), 0);
        check("dis_all_locked", 32'(bus.all_locked), 1);
        en_v[1] = 1'b1;
        run_n(30);

        // 6b: asynchronous reset in the middle of WAIT_LOCK
        block[0] = 1;
        sr_v[0] = 1'b1; run_cycle(); sr_v[0] = 1'b0;
        run_n(20);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        block[0] = 0;
        repeat (2) @(posedge clk);
        bookkeeping_reset();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        run_n(40);

        // randomised soak
        rand_mode = 1'b1;
        run_n(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gth_qpll_reset_ctrl.md
Name: gth_qpll_reset_ctrl

Overview:
- Parametrised per-quad QPLL reset sequencer and lock supervisor for the GTHE4 COMMON blocks.
- Drives one QPLL reset per quad and waits for a filtered lock. It retries on timeout, re-resets on lock loss, and reports aggregate link-ready and failure status.
- Sits between the system clock/reset domain and the qpll0reset/qpll0lock pins of the transceiver common blocks. It replaces the current direct tie of the QPLL reset.

Parameters:
NUM_QUADS, 1, number of COMMON blocks supervised (1..8)
RESET_CYCLES, 64, clk cycles QPLL reset is held asserted per attempt (>=2)
LOCK_FILTER, 16, consecutive synchronised lock-high cycles required to declare lock (>=1)
LOCK_TIMEOUT, 65536, clk cycles allowed in WAIT_LOCK before the attempt fails (>LOCK_FILTER)
MAX_RETRIES, 3, additional reset attempts after the first before entering FAIL (0..15)

Ports:
clk  in  1  free-running system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
quad_en  in  NUM_QUADS  per-quad enable; 0 holds that QPLL in reset (IDLE)
soft_reset  in  NUM_QUADS  per-quad level/pulse; restarts the sequence and clears the retry count
qpll_lock  in  NUM_QUADS  raw QPLL lock from COMMON (asynchronous)
qpll_reset  out  NUM_QUADS  reset to COMMON QPLLxRESET, active-high
quad_locked  out  NUM_QUADS  per-quad filtered lock status
lock_lost  out  NUM_QUADS  one-cycle pulse when a LOCKED quad loses lock
quad_fail  out  NUM_QUADS  per-quad retries exhausted
all_locked  out  1  every enabled quad is LOCKED and at least one quad is enabled
retry_cnt  out  4*NUM_QUADS  attempts used per quad; saturates at 15

Behaviour:
- Reset: clock and reset ports are clk and rst_n. Reset is asynchronous, active-low, with synchronous release into the per-quad FSMs. During reset, every output takes its reset value:
  - qpll_reset all 1s
  - quad_locked, lock_lost, quad_fail, all_locked, retry_cnt all 0
  - synchroniser and counters 0
  - FSM state RESET if quad_en=1, else IDLE (evaluated on the first clock after release)
- Lock input path: qpll_lock passes through a 2-flop synchroniser per bit. "lk" below denotes the synchronised value, which lags the raw input by 2 cycles.
- Per-quad FSM states: IDLE, RESET, WAIT_LOCK, LOCKED, FAIL.
  - IDLE: qpll_reset=1, counters cleared. Goes to RESET when quad_en=1.
  - RESET: qpll_reset=1; reset counter counts 0..RESET_CYCLES-1. Goes to WAIT_LOCK on the terminal count, so the reset pulse width is exactly RESET_CYCLES cycles.
  - WAIT_LOCK: qpll_reset=0; timeout counter increments every cycle. The filter counter increments while lk=1 and clears on lk=0.
    - When the filter reaches LOCK_FILTER: go to LOCKED, clear retry_cnt, assert quad_locked on entry.
    - When timeout reaches LOCK_TIMEOUT without lock, and retry_cnt<MAX_RETRIES: retry_cnt++, go to RESET.
    - On timeout with retry_cnt==MAX_RETRIES: go to FAIL.
    - If filter completion and timeout coincide in the same cycle, lock wins.
  - LOCKED: qpll_reset=0, quad_locked=1.
    - lk=0 for any single cycle: pulse lock_lost for 1 cycle, drop quad_locked in the same cycle, go to RESET.
    - A lock loss does not increment retry_cnt.
  - FAIL: qpll_reset=1, quad_fail=1. The quad remains here until soft_reset or quad_en=0.
- Priority, highest first, evaluated every cycle in any state:
  1. quad_en=0: go to IDLE; clear quad_locked and quad_fail; no lock_lost pulse.
  2. soft_reset=1: go to RESET; retry_cnt=0; clear quad_fail and quad_locked; counters restart. soft_reset held high keeps the quad in RESET with the counter pinned at 0.
  3. Normal FSM transitions.
- Output timing: all outputs are registered, so state-derived outputs change on the cycle after the transition condition.
- all_locked: registered AND of (quad_locked | ~quad_en) across quads, qualified by |quad_en. It deasserts in the same cycle that any enabled quad drops quad_locked.
- Quad independence: quads are fully independent; simultaneous events on different quads do not interact.
- Counter widths: $clog2 of the respective parameter plus 1. No counter wraps; each is cleared on state entry.

Test Plan:
Common settings: NUM_QUADS=2, RESET_CYCLES=8, LOCK_FILTER=4, LOCK_TIMEOUT=100, MAX_RETRIES=2.
1. Nominal bring-up. Stimulus: release rst_n with quad_en=2'b11; drive qpll_lock high 5 cycles after each qpll_reset falls. Required: qpll_reset is high for exactly 8 cycles; quad_locked rises 2+4 cycles after lock is driven high; all_locked=1; retry_cnt=0.
2. Timeout with retry, then lock. Stimulus: hold qpll_lock[0]=0 for the first attempt, then assert it on the second attempt. Required: after 100 WAIT_LOCK cycles, qpll_reset[0] re-pulses for 8 cycles with retry_cnt[3:0]=1; on lock, retry_cnt clears to 0 and quad 1 is unaffected.
3. Retries exhausted. Stimulus: hold qpll_lock[1]=0 permanently. Required: 3 reset pulses occur; quad_fail[1]=1 with qpll_reset[1]=1 held; retry_cnt[7:4]=2; all_locked=0. Then a 1-cycle soft_reset[1] pulse: quad_fail clears, retry_cnt=0, a new 8-cycle reset pulse is issued.
4. Lock loss. Stimulus: from LOCKED, drop qpll_lock[0] for 1 cycle. Required: exactly one lock_lost[0] pulse; quad_locked[0] and all_locked fall; a new 8-cycle reset is issued; retry_cnt unchanged at 0.
5. Glitchy lock during WAIT_LOCK. Stimulus: lock pattern 1,1,1,0,1,1,1,1. Required: the filter restarts on the 0, and quad_locked rises only after the final 4 consecutive highs.
6. Disable and async reset mid-operation. Stimulus: quad_en[1]=0 while LOCKED; separately, assert rst_n=0 mid-WAIT_LOCK. Required: quad 1 goes to IDLE with qpll_reset[1]=1, no lock_lost pulse, and all_locked follows quad 0 only. rst_n=0 immediately forces all outputs to their reset values without waiting for a clock edge.
